axis_mash: RTL and testbench



---
 rtl/mash_pkg.sv | 16 +
 rtl/mash_stage.sv | 34 +++
 rtl/axis_mash.sv | 137 +++++++++++++
 tb/tb_axis_mash.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// mash_pkg: shared constants and helpers for the axis_mash MASH modulator.
// Holds the stage-count limit, the dither LFSR tap mask and the output width rule.
package mash_pkg;

  // Upper bound on cascaded first-order stages supported by axis_mash.
  localparam int MASH_MAX_STAGES = 3;

  // Fibonacci LFSR taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] MASH_LFSR_TAPS = 16'hB400;

  // Signed output width needed to carry the cancellation sum for a given stage count.
  function automatic int mash_out_width(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/mash_stage.sv
// mash_stage: one first-order delta-sigma stage (WIDTH-bit wrapping accumulator).
// The next accumulator value is exposed combinationally so the following stage
// can consume it in the same cycle; the carry out is the stage's 1-bit output.
module mash_stage
  import mash_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  input  logic             cin,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum      = {1'b0, acc} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
  assign acc_next = sum[WIDTH-1:0];
  assign carry    = sum[WIDTH];

  // Accumulator only moves on an accepted sample, otherwise the stage is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/axis_mash.sv
// axis_mash: MASH delta-sigma modulator (1..3 cascaded stages) with AXI-Stream
// input and a single registered AXI-Stream output.
// Optional feature macro: AXIS_MASH_DITHER_EN adds a 16-bit LFSR whose bit 0
// is fed into the stage-1 carry-in on every accepted sample.
module axis_mash
  import mash_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          STAGES    = 2,
  parameter int          OUT_WIDTH = mash_out_width(STAGES),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        aclk,
  input  logic                        arst,
  input  logic signed [WIDTH-1:0]     s_axis_data_tdata,
  input  logic                        s_axis_data_tvalid,
  output logic                        s_axis_data_tready,
  output logic signed [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                        m_axis_data_tvalid,
  input  logic                        m_axis_data_tready
);

  if (STAGES < 1 || STAGES > MASH_MAX_STAGES) begin : g_bad_stages
    $error("axis_mash: STAGES must lie in 1..%0d", MASH_MAX_STAGES);
  end
  if (OUT_WIDTH != mash_out_width(STAGES)) begin : g_bad_out_width
    $error("axis_mash: OUT_WIDTH is derived from STAGES and must not be overridden");
  end

  // Zero-extend a single carry bit into the signed cancellation width.
  function automatic logic signed [OUT_WIDTH-1:0] ext(input logic b);
    return {{(OUT_WIDTH-1){1'b0}}, b};
  endfunction

  logic                          accept;
  logic                          dither_bit;
  logic [STAGES:0][WIDTH-1:0]    x_chain;
  logic [STAGES-1:0]             carry;
  logic signed [OUT_WIDTH-1:0]   term1;
  logic signed [OUT_WIDTH-1:0]   term2;
  logic signed [OUT_WIDTH-1:0]   term3;
  logic signed [OUT_WIDTH-1:0]   y;
  logic                          unused_tail;

  assign s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;

  // Offset binary: flipping the MSB maps the signed range onto 0..2^W-1.
  assign x_chain[0]  = {~s_axis_data_tdata[WIDTH-1], s_axis_data_tdata[WIDTH-2:0]};
  assign unused_tail = ^x_chain[STAGES];

`ifdef AXIS_MASH_DITHER_EN
  logic [15:0] lfsr;

  // Dither LFSR steps once per accepted sample so the dither is tied to the data rate.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], ^(lfsr & MASH_LFSR_TAPS)};
    end
  end

  assign dither_bit = lfsr[0];
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = LFSR_SEED ^ MASH_LFSR_TAPS;
  assign dither_bit = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mash_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (aclk),
      .rst      (arst),
      .en       (accept),
      .x        (x_chain[k]),
      .cin      ((k == 0) ? dither_bit : 1'b0),
      .acc_next (x_chain[k+1]),
      .carry    (carry[k])
    );
  end

  assign term1 = ext(carry[0]);

  if (STAGES >= 2) begin : g_cancel2
    logic c2d;

    // Previous accepted sample's stage-2 carry for the first difference.
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        c2d <= 1'b0;
      end else if (accept) begin
        c2d <= carry[1];
      end
    end

    assign term2 = ext(carry[1]) - ext(c2d);
  end else begin : g_no_cancel2
    assign term2 = '0;
  end

  if (STAGES >= 3) begin : g_cancel3
    logic c3d;
    logic c3dd;

    // Two-deep history of the stage-3 carry for the second difference.
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        c3d  <= 1'b0;
        c3dd <= 1'b0;
      end else if (accept) begin
        c3d  <= carry[2];
        c3dd <= c3d;
      end
    end

    assign term3 = ext(carry[2]) - (ext(c3d) <<< 1) + ext(c3dd);
  end else begin : g_no_cancel3
    assign term3 = '0;
  end

  assign y = term1 + term2 + term3;

  // Single output register: loads on accept, empties when consumed without a refill.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else if (accept) begin
      m_axis_data_tdata  <= y;
      m_axis_data_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mash.sv
// tb_axis_mash: drives STAGES=1,2,3 instances of axis_mash from one shared
// AXI-Stream source/sink and checks them against an integer reference model.
module tb_axis_mash;

  logic               aclk = 1'b0;
  logic               arst = 1'b0;
  logic signed [15:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               m_tready = 1'b0;

  logic               rdy1, rdy2, rdy3;
  logic               vld1, vld2, vld3;
  logic signed [1:0]  dat1;
  logic signed [2:0]  dat2;
  logic signed [3:0]  dat3;

  int   dut_y   [1:3];
  logic dut_rdy [1:3];
  logic dut_vld [1:3];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 aclk = ~aclk;

  axis_mash #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .aclk(aclk), .arst(arst),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(rdy1),
    .m_axis_data_tdata(dat1), .m_axis_data_tvalid(vld1), .m_axis_data_tready(m_tready));

  axis_mash #(.WIDTH(16), .STAGES(2)) u_dut2 (
    .aclk(aclk), .arst(arst),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(rdy2),
    .m_axis_data_tdata(dat2), .m_axis_data_tvalid(vld2), .m_axis_data_tready(m_tready));

  axis_mash #(.WIDTH(16), .STAGES(3)) u_dut3 (
    .aclk(aclk), .arst(arst),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(rdy3),
    .m_axis_data_tdata(dat3), .m_axis_data_tvalid(vld3), .m_axis_data_tready(m_tready));

  // Gather the three instances into indexable arrays.
  always_comb begin
    dut_y[1]   = int'(dat1);
    dut_y[2]   = int'(dat2);
    dut_y[3]   = int'(dat3);
    dut_rdy[1] = rdy1;
    dut_rdy[2] = rdy2;
    dut_rdy[3] = rdy3;
    dut_vld[1] = vld1;
    dut_vld[2] = vld2;
    dut_vld[3] = vld3;
  end

  // Reference model state: per-instance accumulators and carry history as plain ints.
  int macc  [1:3][1:3];
  int mc2d  [1:3];
  int mc3d  [1:3];
  int mc3dd [1:3];
  int my    [1:3];
  bit mvalid = 1'b0;

  // Model: on each accepted sample, run the stage chain arithmetically and apply the
  // cancellation formula; a held output persists until consumed.
  always @(posedge aclk or posedge arst) begin
    int x, sum;
    int c [1:3];
    if (arst) begin
      for (int s = 1; s <= 3; s++) begin
        for (int k = 1; k <= 3; k++) macc[s][k] = 0;
        mc2d[s] = 0; mc3d[s] = 0; mc3dd[s] = 0; my[s] = 0;
      end
      mvalid = 1'b0;
    end else if (s_tvalid && (!mvalid || m_tready)) begin
      for (int s = 1; s <= 3; s++) begin
        x = int'(s_tdata) + 32768;
        for (int k = 1; k <= 3; k++) c[k] = 0;
        for (int k = 1; k <= s; k++) begin
          sum        = macc[s][k] + x;
          c[k]       = sum / 65536;
          macc[s][k] = sum % 65536;
          x          = macc[s][k];
        end
        my[s]    = c[1] + (c[2] - mc2d[s]) + (c[3] - 2 * mc3d[s] + mc3dd[s]);
        mc3dd[s] = mc3d[s];
        mc3d[s]  = c[3];
        mc2d[s]  = c[2];
      end
      mvalid = 1'b1;
    end else if (m_tready) begin
      mvalid = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare process: every negedge outside reset, all instances against the model.
  always @(negedge aclk) begin
    if (!arst) begin
      for (int s = 1; s <= 3; s++) begin
        checkOutput($sformatf("tready_s%0d", s), int'(dut_rdy[s]), int'(!mvalid || m_tready));
        checkOutput($sformatf("tvalid_s%0d", s), int'(dut_vld[s]), int'(mvalid));
        if (mvalid) checkOutput($sformatf("tdata_s%0d", s), dut_y[s], my[s]);
      end
    end
  end

  // Drive one cycle of inputs, then return #1 after the edge that consumes them.
  task automatic applyStimulus(input int d, input bit v, input bit r);
    s_tdata  = 16'(d);
    s_tvalid = v;
    m_tready = r;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int s = 1; s <= 3; s++) begin
      checkOutput($sformatf("%s_tvalid_s%0d", tag, s), int'(dut_vld[s]), 0);
      checkOutput($sformatf("%s_tdata_s%0d", tag, s), dut_y[s], 0);
      checkOutput($sformatf("%s_tready_s%0d", tag, s), int'(dut_rdy[s]), 1);
    end
  endtask

  // Assert reset between edges, check outputs clear at once, release after the next edge.
  task automatic doResetMidStream(input string tag);
    #2 arst = 1'b1;
    #1 checkResetOutputs(tag);
    @(posedge aclk);
    #2 arst = 1'b0;
  endtask

  // Zero input: fixed literal patterns, with a 5-cycle stall after the fourth sample.
  task automatic checkZeroPattern(input string tag);
    int exp1 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp2 [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int held [1:3];
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int s = 1; s <= 3; s++) held[s] = dut_y[s];
        for (int j = 0; j < 5; j++) begin
          applyStimulus(0, 1'b1, 1'b0);
          checkOutput($sformatf("%s_stall_tready", tag), int'(rdy2), 0);
          for (int s = 1; s <= 3; s++)
            checkOutput($sformatf("%s_stall_hold_s%0d", tag, s), dut_y[s], held[s]);
        end
      end
      applyStimulus(0, 1'b1, 1'b1);
      checkOutput($sformatf("%s_zero_s1_%0d", tag, i), dut_y[1], exp1[i]);
      checkOutput($sformatf("%s_zero_s2_%0d", tag, i), dut_y[2], exp2[i]);
    end
  endtask

  initial begin
    int   ones, v, sum_y;
    real  sum_x, mean_x, mean_y, ph;

    #1 arst = 1'b1;
    #1 checkResetOutputs("powerup");
    @(posedge aclk);
    #2 arst = 1'b0;

    $display("[TB] zero-input patterns with backpressure");
    checkZeroPattern("boot");

    $display("[TB] most negative input");
    doResetMidStream("rst_neg");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(-32768, 1'b1, 1'b1);
      checkOutput("neg_s1", dut_y[1], 0);
    end

    $display("[TB] most positive input, full accumulator wrap");
    doResetMidStream("rst_pos");
    applyStimulus(32767, 1'b1, 1'b1);
    checkOutput("pos_s1_first", dut_y[1], 0);
    ones = 0;
    for (int i = 2; i <= 65536; i++) begin
      applyStimulus(32767, 1'b1, 1'b1);
      if (dut_y[1] == 1) ones++;
    end
    checkOutput("pos_s1_ones", ones, 65535);
    applyStimulus(32767, 1'b1, 1'b1);
    checkOutput("pos_s1_wrap", dut_y[1], 0);

    $display("[TB] sine input on three stages");
    doResetMidStream("rst_sine");
    for (int p = 0; p < 10; p++) begin
      sum_y = 0;
      sum_x = 0.0;
      for (int i = 0; i < 800; i++) begin
        ph = 2.0 * 3.14159265358979 * real'(i) / 800.0;
        v  = 8000 + $rtoi(16000.0 * $sin(ph));
        applyStimulus(v, 1'b1, 1'b1);
        checkOutput("sine_s3_range", int'(dut_y[3] >= -3 && dut_y[3] <= 4), 1);
        sum_y += dut_y[3];
        sum_x += real'(v + 32768) / 65536.0;
      end
      mean_x = sum_x / 800.0;
      mean_y = real'(sum_y) / 800.0;
      checkOutput($sformatf("sine_s3_mean_p%0d", p),
                  int'((mean_y - mean_x <= 0.01 * mean_x) && (mean_x - mean_y <= 0.01 * mean_x)), 1);
    end

    $display("[TB] random traffic with mid-stream reset");
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        doResetMidStream("rst_rand");
        checkZeroPattern("rerun");
      end
      applyStimulus(int'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
